// File: rtl/uart_frame_rx.sv
// 8N1 UART receiver that stores a fixed-length frame of bytes into an external RAM.
// A byte is written one cycle after its stop-bit sample; there is no backpressure and the line is never stalled.
module uart_frame_rx #(
  parameter int CLKS_PER_BIT    = 10850,
  parameter int BYTES_PER_FRAME = 9216,
  parameter int ADDR_W          = 15
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Rx,
  input  logic              i_Frame_Clear,
  output logic [7:0]        o_Byte,
  output logic              o_Wr_En,
  output logic [ADDR_W-1:0] o_Wr_Addr,
  output logic              o_Rx_Active,
  output logic              o_Frame_Done,
  output logic              o_Frame_Error
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]     HALF_CNT  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]     LAST_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(BYTES_PER_FRAME - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     bit_cnt, bit_cnt_nxt;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic [7:0]        shift, shift_nxt;
  logic              stop_good, stop_bad;
  logic              rx_meta, rx_s;
  logic [ADDR_W-1:0] byte_cnt;

  // Idle-high reset value keeps a released reset from looking like a start bit.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_Rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    stop_good   = 1'b0;
    stop_bad    = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt   = START;
          bit_cnt_nxt = '0;
        end
      end
      START: begin
        // Re-check the line mid start bit so short glitches are rejected.
        if (bit_cnt == HALF_CNT) begin
          bit_cnt_nxt = '0;
          bit_idx_nxt = '0;
          state_nxt   = rx_s ? IDLE : DATA;
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_cnt == LAST_CNT) begin
          bit_cnt_nxt        = '0;
          shift_nxt[bit_idx] = rx_s;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_cnt == LAST_CNT) begin
          bit_cnt_nxt = '0;
          state_nxt   = IDLE;
          stop_good   = rx_s;
          stop_bad    = !rx_s;
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        bit_cnt_nxt = '0;
      end
    endcase
  end

  assign o_Rx_Active = (state != IDLE);

  // Write port: a clear in the same cycle as a good stop drops the write.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Byte    <= '0;
      o_Wr_En   <= 1'b0;
      o_Wr_Addr <= '0;
    end else begin
      o_Wr_En <= 1'b0;
      if (stop_good) begin
        o_Byte <= shift;
        if (!o_Frame_Done && !i_Frame_Clear) begin
          o_Wr_En   <= 1'b1;
          o_Wr_Addr <= byte_cnt;
        end
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      byte_cnt      <= '0;
      o_Frame_Done  <= 1'b0;
      o_Frame_Error <= 1'b0;
    end else if (i_Frame_Clear) begin
      byte_cnt      <= '0;
      o_Frame_Done  <= 1'b0;
      o_Frame_Error <= 1'b0;
    end else begin
      if (stop_bad) begin
        o_Frame_Error <= 1'b1;
      end
      // Count saturates at the frame length: once done, no further increments.
      if (stop_good && !o_Frame_Done) begin
        byte_cnt <= byte_cnt + 1'b1;
        if (byte_cnt == LAST_BYTE) begin
          o_Frame_Done <= 1'b1;
        end
      end
    end
  end

endmodule
